// File: rtl/fft_7_pkg.sv
`default_nettype none
// =============================================================================
// fft_7_pkg : shared widths, constants, state encoding and sample-format
//             helpers for FFT stage 7.
// Revision  : 1.0
// =============================================================================
package fft_7_pkg;

    localparam int MAG_W      = 8;
    localparam int TW_FRAC    = 7;
    localparam int ROUND_BIAS = 64;
    localparam int SAT_MAX    = 255;

    localparam int SMP_W  = MAG_W + 1;
    localparam int PROD_W = 2 * MAG_W;
    localparam int TC_W   = 11;
    localparam int SUM_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Sign-magnitude to two's complement; a negative zero becomes plain zero.
    function automatic logic signed [TC_W-1:0] sm_to_tc(input logic neg, input logic [MAG_W:0] mag);
        logic signed [TC_W-1:0] v;
        v = $signed({{(TC_W-MAG_W-1){1'b0}}, mag});
        return neg ? -v : v;
    endfunction

    // Floor-halve, clamp to +/-SAT_MAX and return sign-magnitude with a positive zero.
    function automatic logic [MAG_W:0] half_sat_sm(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] h;
        logic signed [SUM_W-1:0] m;
        h = s >>> 1;
        if (h > SUM_W'(SAT_MAX)) begin
            return {1'b0, MAG_W'(SAT_MAX)};
        end
        if (h < -SUM_W'(SAT_MAX)) begin
            return {1'b1, MAG_W'(SAT_MAX)};
        end
        m = (h < 0) ? -h : h;
        return {(h < 0), MAG_W'(m)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_7.sv
`default_nettype none
// =============================================================================
// seq_mult_7 : unsigned MAG_W x MAG_W shift-add multiplier, one multiplier bit
//              per clock; done pulses with the product 8 cycles after start.
// Revision   : 1.0
// =============================================================================
module seq_mult_7
    import fft_7_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MAG_W-1:0]  a,
    input  logic [MAG_W-1:0]  b,
    output logic              done,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [MAG_W-1:0]  mplier_q, mplier_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            // Bit 0 is folded into the load edge so eight edges cover all bits.
            mcand_d  = PROD_W'(a) << 1;
            acc_d    = b[0] ? PROD_W'(a) : '0;
            mplier_d = b >> 1;
            cnt_d    = 3'd6;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule
`default_nettype wire

// File: rtl/butterfly_7.sv
`default_nettype none
// =============================================================================
// butterfly_7 : radix-2 DIT butterfly for FFT stage 7, sign-magnitude I/O,
//               y0/y1 = (x0 +/- x1*W)/2. Option macro: BUTTERFLY_ROUND_EN
//               (round product magnitudes half-up instead of truncating).
// Revision    : 1.0
// =============================================================================
module butterfly_7
    import fft_7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SMP_W-1:0] x0_re,
    input  logic [SMP_W-1:0] x0_im,
    input  logic [SMP_W-1:0] x1_re,
    input  logic [SMP_W-1:0] x1_im,
    input  logic [SMP_W-1:0] w_re,
    input  logic [SMP_W-1:0] w_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SMP_W-1:0] y0_re,
    output logic [SMP_W-1:0] y0_im,
    output logic [SMP_W-1:0] y1_re,
    output logic [SMP_W-1:0] y1_im
);

    state_t                 state_q, state_d;
    logic [SMP_W-1:0]       x0_re_q, x0_re_d, x0_im_q, x0_im_d;
    logic [SMP_W-1:0]       x1_re_q, x1_re_d, x1_im_q, x1_im_d;
    logic [SMP_W-1:0]       w_re_q, w_re_d, w_im_q, w_im_d;
    logic [1:0]             k_q, k_d;
    logic                   start_pend_q, start_pend_d;
    logic signed [TC_W-1:0] t_re_q, t_re_d, t_im_q, t_im_d;
    logic [SMP_W-1:0]       y0_re_q, y0_re_d, y0_im_q, y0_im_d;
    logic [SMP_W-1:0]       y1_re_q, y1_re_d, y1_im_q, y1_im_d;

    logic                   mult_start, mult_done;
    logic [PROD_W-1:0]      mult_prod;
    logic [1:0]             sel;
    logic [SMP_W-1:0]       opx [4];
    logic [SMP_W-1:0]       opw [4];
    logic [SMP_W-1:0]       cur_x, cur_w;
    logic [PROD_W-1:0]      biased;
    logic [SMP_W-1:0]       scaled;
    logic                   p_neg;
    logic signed [TC_W-1:0] p_tc;
    logic signed [TC_W-1:0] x0r_tc, x0i_tc;
    logic signed [SUM_W-1:0] x0r_w, x0i_w, tr_w, ti_w;

    // Product order k0..k3: x1re*wre, x1im*wim, x1re*wim, x1im*wre.
    always_comb begin
        opx[0] = x1_re_q;  opw[0] = w_re_q;
        opx[1] = x1_im_q;  opw[1] = w_im_q;
        opx[2] = x1_re_q;  opw[2] = w_im_q;
        opx[3] = x1_im_q;  opw[3] = w_re_q;
    end

    always_comb begin
        sel    = start_pend_q ? k_q : k_q + 2'd1;
        cur_x  = opx[k_q];
        cur_w  = opw[k_q];
`ifdef BUTTERFLY_ROUND_EN
        biased = mult_prod + PROD_W'(ROUND_BIAS);
`else
        biased = mult_prod;
`endif
        scaled = SMP_W'(biased >> TW_FRAC);
        p_neg  = (cur_x[MAG_W] ^ cur_w[MAG_W]) && (mult_prod != '0);
        p_tc   = sm_to_tc(p_neg, scaled);
        x0r_tc = sm_to_tc(x0_re_q[MAG_W], {1'b0, x0_re_q[MAG_W-1:0]});
        x0i_tc = sm_to_tc(x0_im_q[MAG_W], {1'b0, x0_im_q[MAG_W-1:0]});
        x0r_w  = $signed({x0r_tc[TC_W-1], x0r_tc});
        x0i_w  = $signed({x0i_tc[TC_W-1], x0i_tc});
        tr_w   = $signed({t_re_q[TC_W-1], t_re_q});
        ti_w   = $signed({t_im_q[TC_W-1], t_im_q});
    end

    seq_mult_7 u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (mult_start),
        .a     (opx[sel][MAG_W-1:0]),
        .b     (opw[sel][MAG_W-1:0]),
        .done  (mult_done),
        .prod  (mult_prod)
    );

    always_comb begin
        state_d      = state_q;
        x0_re_d      = x0_re_q;
        x0_im_d      = x0_im_q;
        x1_re_d      = x1_re_q;
        x1_im_d      = x1_im_q;
        w_re_d       = w_re_q;
        w_im_d       = w_im_q;
        k_d          = k_q;
        start_pend_d = start_pend_q;
        t_re_d       = t_re_q;
        t_im_d       = t_im_q;
        y0_re_d      = y0_re_q;
        y0_im_d      = y0_im_q;
        y1_re_d      = y1_re_q;
        y1_im_d      = y1_im_q;
        mult_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_re_d      = x0_re;
                    x0_im_d      = x0_im;
                    x1_re_d      = x1_re;
                    x1_im_d      = x1_im;
                    w_re_d       = w_re;
                    w_im_d       = w_im;
                    k_d          = 2'd0;
                    start_pend_d = 1'b1;
                    state_d      = MUL;
                end
            end
            MUL: begin
                if (start_pend_q) begin
                    mult_start   = 1'b1;
                    start_pend_d = 1'b0;
                end else if (mult_done) begin
                    case (k_q)
                        2'd0:    t_re_d = p_tc;
                        2'd1:    t_re_d = t_re_q - p_tc;
                        2'd2:    t_im_d = p_tc;
                        default: t_im_d = t_im_q + p_tc;
                    endcase
                    if (k_q == 2'd3) begin
                        state_d = SUM;
                    end else begin
                        k_d        = k_q + 2'd1;
                        mult_start = 1'b1;
                    end
                end
            end
            SUM: begin
                y0_re_d = half_sat_sm(x0r_w + tr_w);
                y0_im_d = half_sat_sm(x0i_w + ti_w);
                y1_re_d = half_sat_sm(x0r_w - tr_w);
                y1_im_d = half_sat_sm(x0i_w - ti_w);
                state_d = HOLD;
            end
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x0_re_q      <= '0;
            x0_im_q      <= '0;
            x1_re_q      <= '0;
            x1_im_q      <= '0;
            w_re_q       <= '0;
            w_im_q       <= '0;
            k_q          <= '0;
            start_pend_q <= 1'b0;
            t_re_q       <= '0;
            t_im_q       <= '0;
            y0_re_q      <= '0;
            y0_im_q      <= '0;
            y1_re_q      <= '0;
            y1_im_q      <= '0;
        end else begin
            state_q      <= state_d;
            x0_re_q      <= x0_re_d;
            x0_im_q      <= x0_im_d;
            x1_re_q      <= x1_re_d;
            x1_im_q      <= x1_im_d;
            w_re_q       <= w_re_d;
            w_im_q       <= w_im_d;
            k_q          <= k_d;
            start_pend_q <= start_pend_d;
            t_re_q       <= t_re_d;
            t_im_q       <= t_im_d;
            y0_re_q      <= y0_re_d;
            y0_im_q      <= y0_im_d;
            y1_re_q      <= y1_re_d;
            y1_im_q      <= y1_im_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign y0_re     = y0_re_q;
    assign y0_im     = y0_im_q;
    assign y1_re     = y1_re_q;
    assign y1_im     = y1_im_q;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_7.sv
`default_nettype none
// =============================================================================
// tb_butterfly_7 : directed self-checking bench for butterfly_7.
// Revision       : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_butterfly_7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [8:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0, w_re = '0, w_im = '0;
    logic [8:0] y0_re, y0_im, y1_re, y1_im;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    butterfly_7 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0_re     (x0_re),
        .x0_im     (x0_im),
        .x1_re     (x1_re),
        .x1_im     (x1_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0_re     (y0_re),
        .y0_im     (y0_im),
        .y1_re     (y1_re),
        .y1_im     (y1_im)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [8:0] a0r, a0i, a1r, a1i, wr, wi);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        x0_re = a0r; x0_im = a0i; x1_re = a1r; x1_im = a1i; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x0_re = 9'h1AB; x0_im = 9'h0CD; x1_re = 9'h1EF; x1_im = 9'h077; w_re = 9'h155; w_im = 9'h0AA;
    endtask

    task automatic run_op(input string tag, input logic [8:0] a0r, a0i, a1r, a1i, wr, wi);
        int lat;
        accept(a0r, a0i, a1r, a1i, wr, wi);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 34);
    endtask

    task automatic check_y(input string tag, input logic [8:0] e0r, e0i, e1r, e1i);
        check({tag, "_y0_re"}, {23'd0, y0_re}, {23'd0, e0r});
        check({tag, "_y0_im"}, {23'd0, y0_im}, {23'd0, e0i});
        check({tag, "_y1_re"}, {23'd0, y1_re}, {23'd0, e1r});
        check({tag, "_y1_im"}, {23'd0, y1_im}, {23'd0, e1i});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic       stable_ok;
        logic       ready_seen;
        logic [8:0] h0r, h0i, h1r, h1i;
        logic [8:0] e_y0_re;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_y("rst", 9'h000, 9'h000, 9'h000, 9'h000);

        // 1: unity twiddle
        run_op("unity", 9'h064, 9'h000, 9'h032, 9'h000, 9'h080, 9'h000);
        check("unity_in_ready_hold", {31'd0, in_ready}, 32'd0);
        check_y("unity", 9'h04B, 9'h000, 9'h019, 9'h000);
        release_out();

        // 2: -j twiddle
        run_op("mj", 9'h000, 9'h000, 9'h028, 9'h014, 9'h000, 9'h180);
        check_y("mj", 9'h00A, 9'h114, 9'h10A, 9'h014);
        release_out();

        // 3: saturation and floor halving
        run_op("sat", 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h000);
        check_y("sat", 9'h0FF, 9'h0FF, 9'h17F, 9'h17F);
        release_out();

        // 4: product rounding
        run_op("rnd", 9'h000, 9'h000, 9'h003, 9'h000, 9'h040, 9'h000);
`ifdef BUTTERFLY_ROUND_EN
        e_y0_re = 9'h001;
`else
        e_y0_re = 9'h000;
`endif
        check_y("rnd", e_y0_re, 9'h000, 9'h101, 9'h000);
        release_out();

        // 5: backpressure with competing input
        run_op("bp", 9'h064, 9'h000, 9'h032, 9'h000, 9'h080, 9'h000);
        h0r = y0_re; h0i = y0_im; h1r = y1_re; h1i = y1_im;
        stable_ok  = 1'b1;
        ready_seen = 1'b0;
        x0_re = 9'h010; x0_im = 9'h020; x1_re = 9'h030; x1_im = 9'h040; w_re = 9'h080; w_im = 9'h000;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || y0_re !== h0r || y0_im !== h0i || y1_re !== h1r || y1_im !== h1i)
                stable_ok = 1'b0;
            if (in_ready)
                ready_seen = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_stable", {31'd0, stable_ok}, 32'd1);
        check("bp_in_ready_low", {31'd0, ready_seen}, 32'd0);
        check_y("bp", 9'h04B, 9'h000, 9'h019, 9'h000);
        release_out();
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

        // 6: reset mid-MUL, then negative-zero operands
        accept(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_y("mrst", 9'h000, 9'h000, 9'h000, 9'h000);
        run_op("nz", 9'h100, 9'h100, 9'h000, 9'h000, 9'h080, 9'h1FF);
        check_y("nz", 9'h000, 9'h000, 9'h000, 9'h000);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
